mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one external memory port (req/we/size/addr/data plus active-low ack) between the processor's instruction-fetch side and its data load/store side.
- Sits between top's fetch and memory stages and the memory bus driven by the bench.
- Data side has fixed priority, with a starvation bound for instruction fetch.
- A watchdog terminates transactions that are never acknowledged.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, max consecutive D grants while i_req pending before I is forced (min 1)
- TIMEOUT_CYCLES, 64, cycles in BUSY without ack before abort; 0 disables
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- i_req  in  1  fetch request, level, held until i_ack_n low
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, valid while i_ack_n low
- i_ack_n  out  1  fetch done, active-low, one-cycle pulse
- d_req  in  1  data request, level, held until d_ack_n low
- d_we  in  1  1 = store
- d_size  in  2  00 word, 01 half, 10 byte
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ack_n low
- d_ack_n  out  1  data done, active-low, one-cycle pulse
- m_req  out  1  memory request
- m_we  out  1  memory write
- m_size  out  2  memory access size
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data
- m_ack_n  in  1  memory ack, active-low
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- All outputs are registered.
- Reset values: m_req=0, m_we=0, m_size=00, m_addr=0, m_wdata=0, i_ack_n=1, d_ack_n=1, i_rdata=0, d_rdata=0, timeout_err=0.
- Reset also clears state (to IDLE), the streak counter and the watchdog counter.
- Reset mid-transaction abandons it: m_req is 0 after the reset edge and no ack is issued.
- State machine has four states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, grant selection:
  - If d_req=1 and (i_req=0 or streak<MAX_D_STREAK), grant D and go to BUSY_D.
  - Else if i_req=1, grant I and go to BUSY_I.
  - On grant, latch addr/we/size/wdata into the m_* registers and set m_req=1.
  - An I grant drives m_we=0 and m_size=00.
- Streak counter:
  - Increments on a D grant while i_req=1, saturating at MAX_D_STREAK.
  - Clears on an I grant, and on a D grant while i_req=0.
- BUSY_x: m_req and the m_* fields are held stable. On m_ack_n=0:
  - Capture m_rdata into the owner's rdata (stores capture it too, value unused).
  - Drive the owner's ack_n=0 next cycle, clear m_req, go to RESP.
- Watchdog:
  - In BUSY, the counter increments each cycle without ack.
  - On reaching TIMEOUT_CYCLES: owner rdata=ERR_DATA, owner ack_n=0, timeout_err=1 (same cycle as the ack), m_req=0, go to RESP.
  - If m_ack_n=0 in the same cycle the count is reached, the ack wins: no error, real data returned.
- RESP: owner ack_n=0 for exactly this cycle. No grant is made in RESP. Next state is IDLE.
  - A requester wanting back-to-back access keeps req high; it is re-arbitrated in IDLE.
- Latency:
  - Request in IDLE at cycle N gives m_req=1 at N+1.
  - m_ack_n=0 sampled at cycle M gives owner ack_n=0 at M+1; IDLE at M+2.
  - Minimum round trip is 4 cycles for a 1-cycle memory.
- m_ack_n=0 in IDLE or RESP is ignored.
- Requests that change while not granted are not checked; only the values sampled at grant are used.

Decomposition:
- Package mem_bus_pkg holds:
  - state enum (IDLE, BUSY_I, BUSY_D, RESP)
  - size constants SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10
  - default ERR_DATA
- Single module; no sub-module is needed. The watchdog counter stays inline.

Test Plan:
- Single fetch: i_req=1, addr 0x0000_0010; memory acks 1 cycle after m_req with 0x1234_5678 -> m_req=1 at N+1, m_we=0, m_size=00; i_ack_n=0 one cycle with i_rdata=0x1234_5678; i_req held -> next m_req 2 cycles after ack.
- Simultaneous: i_req=d_req=1 in IDLE, d_we=1, d_size=10, d_addr 0xF000_0000, d_wdata=0x41 -> D granted first, m_we=1, m_size=10, m_wdata=0x41; I granted after d_ack_n pulse.
- Starvation: d_req held high with immediate acks, i_req held high, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Timeout: TIMEOUT_CYCLES=8, d_req load, m_ack_n stays 1 -> after 8 BUSY cycles d_ack_n=0 with d_rdata=0xDEAD_BEEF and timeout_err=1 same cycle; next i_req served normally.
- Ack on timeout boundary: m_ack_n=0 on the 8th BUSY cycle with 0xCAFE_0001 -> timeout_err stays 0, d_rdata=0xCAFE_0001.
- Reset mid-op: assert rst for one cycle while in BUSY_I -> all outputs at reset values after the edge, no i_ack_n pulse; fresh i_req completes normally afterwards.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for the memory bus arbiter
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    RESP   = 2'b11
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/data arbiter for a single memory port
// Data side wins by default; a streak limit and an ack watchdog bound every wait.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                MAX_D_STREAK   = 4,
  parameter int                TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(DEF_ERR_DATA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack_n,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack_n,
  output logic              m_req,
  output logic              m_we,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack_n,
  output logic              timeout_err
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int WW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [WW-1:0] WD_LAST    = WW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t            state, state_n;
  logic [SW-1:0]     streak, streak_n;
  logic [WW-1:0]     wd, wd_n;
  logic              m_req_n, m_we_n, i_ack_n_n, d_ack_n_n, timeout_err_n;
  logic [1:0]        m_size_n;
  logic [ADDR_W-1:0] m_addr_n;
  logic [DATA_W-1:0] m_wdata_n, i_rdata_n, d_rdata_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      streak      <= '0;
      wd          <= '0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_size      <= SZ_WORD;
      m_addr      <= '0;
      m_wdata     <= '0;
      i_ack_n     <= 1'b1;
      d_ack_n     <= 1'b1;
      i_rdata     <= '0;
      d_rdata     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      streak      <= streak_n;
      wd          <= wd_n;
      m_req       <= m_req_n;
      m_we        <= m_we_n;
      m_size      <= m_size_n;
      m_addr      <= m_addr_n;
      m_wdata     <= m_wdata_n;
      i_ack_n     <= i_ack_n_n;
      d_ack_n     <= d_ack_n_n;
      i_rdata     <= i_rdata_n;
      d_rdata     <= d_rdata_n;
      timeout_err <= timeout_err_n;
    end
  end

  always_comb begin
    state_n       = state;
    streak_n      = streak;
    wd_n          = wd;
    m_req_n       = m_req;
    m_we_n        = m_we;
    m_size_n      = m_size;
    m_addr_n      = m_addr;
    m_wdata_n     = m_wdata;
    i_rdata_n     = i_rdata;
    d_rdata_n     = d_rdata;
    i_ack_n_n     = 1'b1;
    d_ack_n_n     = 1'b1;
    timeout_err_n = 1'b0;

    case (state)
      IDLE: begin
        // The D grant condition already guarantees streak < MAX when i_req is high.
        if (d_req && (!i_req || streak < STREAK_MAX)) begin
          state_n   = BUSY_D;
          m_req_n   = 1'b1;
          m_we_n    = d_we;
          m_size_n  = d_size;
          m_addr_n  = d_addr;
          m_wdata_n = d_wdata;
          wd_n      = '0;
          streak_n  = i_req ? streak + SW'(1) : '0;
        end else if (i_req) begin
          state_n  = BUSY_I;
          m_req_n  = 1'b1;
          m_we_n   = 1'b0;
          m_size_n = SZ_WORD;
          m_addr_n = i_addr;
          wd_n     = '0;
          streak_n = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (!m_ack_n) begin
          if (state == BUSY_I) begin
            i_rdata_n = m_rdata;
            i_ack_n_n = 1'b0;
          end else begin
            d_rdata_n = m_rdata;
            d_ack_n_n = 1'b0;
          end
          m_req_n = 1'b0;
          state_n = RESP;
        end else if (TIMEOUT_CYCLES != 0 && wd == WD_LAST) begin
          if (state == BUSY_I) begin
            i_rdata_n = ERR_DATA;
            i_ack_n_n = 1'b0;
          end else begin
            d_rdata_n = ERR_DATA;
            d_ack_n_n = 1'b0;
          end
          timeout_err_n = 1'b1;
          m_req_n       = 1'b0;
          state_n       = RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          wd_n = wd + WW'(1);
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule
